// File: rtl/flght_cntrl_pid.sv
// Quad-rotor PID flight controller: per-axis P, D and clamped I terms, a four-motor mix,
// and an idle/calibrate/ramp/run sequencer that slew-limits motor spin-up.
module flght_cntrl_pid #(
  parameter int SPD_W         = 11,
  parameter int D_DEPTH       = 12,
  parameter int D_COEFF       = 7,
  parameter int I_SHIFT       = 6,
  parameter int I_LIM         = 64,
  parameter int CAL_SPEED     = 'h290,
  parameter int MIN_RUN_SPEED = 'h2C0,
  parameter int SLEW_STEP     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic                    inertial_cal,
  input  logic                    arm,
  input  logic signed [15:0]      d_ptch,
  input  logic signed [15:0]      d_roll,
  input  logic signed [15:0]      d_yaw,
  input  logic signed [15:0]      ptch,
  input  logic signed [15:0]      roll,
  input  logic signed [15:0]      yaw,
  input  logic [8:0]              thrst,
  output logic [SPD_W-1:0]        frnt_spd,
  output logic [SPD_W-1:0]        bck_spd,
  output logic [SPD_W-1:0]        lft_spd,
  output logic [SPD_W-1:0]        rght_spd,
  output logic                    running
);

  // vld is a one-cycle strobe with no backpressure: every cycle it is high, one inertial
  // sample is consumed (history shift, integrator step, ramp step).

  typedef enum logic [1:0] {S_IDLE, S_CAL, S_RAMP, S_RUN} state_t;
  typedef logic signed [31:0] s32_t;

  localparam s32_t             ACC_MAX = s32_t'(I_LIM * (2 ** I_SHIFT));
  localparam s32_t             SPD_MAX = s32_t'((2 ** SPD_W) - 1);
  localparam logic [SPD_W-1:0] CAL_SPD = SPD_W'(CAL_SPEED);
  localparam logic [SPD_W-1:0] SLEW    = SPD_W'(SLEW_STEP);

  state_t state_q, state_d;

  logic signed [15:0] act [3];
  logic signed [15:0] des [3];
  logic signed [9:0]  hist_q [3][D_DEPTH];
  s32_t               acc_q [3];
  s32_t               acc_d [3];
  s32_t               err [3];
  s32_t               pterm [3];
  s32_t               diff [3];
  s32_t               dterm [3];
  s32_t               corr [3];
  s32_t               base;
  s32_t               mix [4];
  s32_t               gap [4];
  logic [SPD_W-1:0]   tgt_d [4];
  logic [SPD_W-1:0]   tgt_q [4];
  logic [SPD_W-1:0]   spd_q [4];
  logic [SPD_W-1:0]   spd_d [4];
  logic [SPD_W-1:0]   spd_step [4];
  logic               ramp_done;

  assign act[0] = ptch;
  assign act[1] = roll;
  assign act[2] = yaw;
  assign des[0] = d_ptch;
  assign des[1] = d_roll;
  assign des[2] = d_yaw;

  function automatic s32_t sat(input s32_t v, input s32_t lo, input s32_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Target uses the integrator value after this cycle's step so a vld edge sees its own error.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      err[a]   = sat(s32_t'(act[a]) - s32_t'(des[a]), -512, 511);
      pterm[a] = (err[a] >>> 1) + (err[a] >>> 3);
      diff[a]  = sat(err[a] - s32_t'(hist_q[a][D_DEPTH-1]), -64, 63);
      dterm[a] = diff[a] * D_COEFF;
      if (state_q != S_RUN)
        acc_d[a] = '0;
      else if (vld)
        acc_d[a] = sat(acc_q[a] + err[a], -ACC_MAX, ACC_MAX);
      else
        acc_d[a] = acc_q[a];
      corr[a] = pterm[a] + dterm[a] + (acc_d[a] >>> I_SHIFT);
    end
    base   = s32_t'({23'd0, thrst}) + s32_t'(MIN_RUN_SPEED);
    mix[0] = base - corr[0] - corr[2];
    mix[1] = base + corr[0] - corr[2];
    mix[2] = base - corr[1] + corr[2];
    mix[3] = base + corr[1] + corr[2];
    for (int m = 0; m < 4; m++)
      tgt_d[m] = SPD_W'(sat(mix[m], 0, SPD_MAX));
  end

  always_comb begin
    ramp_done = 1'b1;
    for (int m = 0; m < 4; m++) begin
      gap[m] = $signed(32'(tgt_q[m])) - $signed(32'(spd_q[m]));
      if (gap[m] > s32_t'(SLEW_STEP))
        spd_step[m] = spd_q[m] + SLEW;
      else if (gap[m] < -s32_t'(SLEW_STEP))
        spd_step[m] = spd_q[m] - SLEW;
      else
        spd_step[m] = tgt_q[m];
      if (spd_step[m] != tgt_q[m])
        ramp_done = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (inertial_cal) begin
      state_d = S_CAL;
    end else begin
      case (state_q)
        S_CAL:   state_d = arm ? S_RAMP : S_IDLE;
        S_IDLE:  if (arm) state_d = S_RAMP;
        S_RAMP:  if (!arm) state_d = S_IDLE;
                 else if (vld && ramp_done) state_d = S_RUN;
        S_RUN:   if (!arm) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Entering RAMP holds the current speeds; stepping starts on the next vld.
    spd_d = spd_q;
    case (state_d)
      S_CAL:   for (int m = 0; m < 4; m++) spd_d[m] = CAL_SPD;
      S_IDLE:  for (int m = 0; m < 4; m++) spd_d[m] = '0;
      S_RAMP:  if (state_q == S_RAMP && vld) spd_d = spd_step;
      S_RUN:   spd_d = tgt_q;
      default: for (int m = 0; m < 4; m++) spd_d[m] = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int m = 0; m < 4; m++) begin
        tgt_q[m] <= '0;
        spd_q[m] <= '0;
      end
      for (int a = 0; a < 3; a++) begin
        acc_q[a] <= '0;
        for (int i = 0; i < D_DEPTH; i++)
          hist_q[a][i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      spd_q   <= spd_d;
      acc_q   <= acc_d;
      if (vld) begin
        for (int a = 0; a < 3; a++) begin
          hist_q[a][0] <= err[a][9:0];
          for (int i = 1; i < D_DEPTH; i++)
            hist_q[a][i] <= hist_q[a][i-1];
        end
      end
    end
  end

  assign frnt_spd = spd_q[0];
  assign bck_spd  = spd_q[1];
  assign lft_spd  = spd_q[2];
  assign rght_spd = spd_q[3];
  assign running  = (state_q == S_RUN);

endmodule
